fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register and feeds the decode/execute datapath.
- Owns the fetch PC and issues requests to a synchronous instruction memory with one cycle of read latency.
- Buffers returned words in a small skid FIFO so that decode stalls never drop an instruction.
- Presents {instruction, PC, PC+4, valid} to the IF/ID register and accepts branch redirects from execute.

Parameters:
- WIDTH, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, skid FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- BranchTaken  in  1  redirect request from execute (PCSrc qualified by condition).
- BranchTarget  in  WIDTH  redirect address; bits [1:0] ignored and forced 0.
- StallD  in  1  decode cannot accept this cycle.
- IMemReq  out  1  fetch request strobe.
- IMemAddr  out  WIDTH  word-aligned fetch address.
- IMemData  in  WIDTH  instruction word, valid the cycle after IMemReq.
- InstrF  out  WIDTH  instruction at FIFO head.
- PCF  out  WIDTH  address of InstrF.
- PCPlus4F  out  WIDTH  PCF + 4.
- ValidF  out  1  InstrF/PCF/PCPlus4F hold a real instruction.

Behaviour:
- Reset (async assert, sync release):
  - FetchPC = RESET_PC; FIFO empty; in-flight flag clear.
  - IMemReq = 0, ValidF = 0, InstrF = 0, PCF = 0, PCPlus4F = 0.
  - No request issues while reset is low.
- State:
  - FetchPC register.
  - inflight bit (request issued last cycle) plus its address.
  - FIFO of {instr, pc} entries with count, head and tail pointers; pointers wrap mod BUF_DEPTH.
- Pop: pop = ValidF & ~StallD & ~BranchTaken. The head entry is removed at the clock edge.
- Issue: IMemReq = ~BranchTaken & ((count + inflight − pop) < BUF_DEPTH).
  - IMemAddr = FetchPC.
  - On issue: FetchPC ← FetchPC + 4 (mod 2^WIDTH, wraps silently); inflight ← 1. Otherwise inflight ← 0.
- Return: in any cycle with inflight = 1, IMemData and the stored address are pushed at the clock edge. Push and pop in the same cycle leave count unchanged.
- Output:
  - ValidF = (count != 0).
  - InstrF, PCF and PCPlus4F come from the head entry when ValidF = 1, and are 0 when ValidF = 0.
- Latency and throughput:
  - Request in cycle n → data in n+1 → ValidF in n+2.
  - Steady state with StallD = 0: one instruction per cycle.
- StallD held high:
  - Head entry holds stable.
  - Issue stops once count + inflight reaches BUF_DEPTH.
  - The in-flight word is still captured, never lost.
  - The FIFO never overflows. A push while full is a design error; the bench asserts on it.
- Redirect (BranchTaken = 1 in cycle n), highest priority:
  - IMemReq = 0 in cycle n.
  - Any return arriving in cycle n is discarded.
  - FIFO cleared and inflight cleared at the edge.
  - FetchPC ← {BranchTarget[WIDTH-1:2], 2'b00}.
  - ValidF = 0 in cycle n+1.
  - Target is requested in n+1 and valid in n+3.
  - StallD is ignored during a redirect.
- Back-to-back redirects: the last one wins; each one flushes again.
- Reset mid-operation: immediate return to the reset state. In-flight data is discarded.

Test Plan:
- Reset release, StallD = 0, memory returns addr + 32'hA000 → IMemAddr 0,4,8,… on consecutive cycles. First ValidF two cycles after the first IMemReq, with PCF = 0 and InstrF = 32'h0000_A000. Then one instruction per cycle; PCPlus4F = PCF + 4.
- StallD high for 5 cycles mid-stream (head PCF = 0x10) → PCF stays 0x10. IMemReq drops after count = 2. No PC skipped or duplicated after release: 0x10, 0x14, 0x18 in order.
- BranchTaken with BranchTarget = 0x103 while the FIFO holds 2 entries and a request is in flight → ValidF = 0 next cycle. IMemAddr = 0x100 the cycle after the redirect. First valid PCF = 0x100, no stale 0x1x instruction appears.
- Redirect on two consecutive cycles (targets 0x40 then 0x80) → only 0x80-stream instructions emerge.
- FetchPC = 0xFFFF_FFFC → next IMemAddr = 0x0000_0000 (wrap). PCPlus4F of that instruction = 0.
- reset pulsed low mid-stream with StallD = 1 and the FIFO full → all outputs 0 asynchronously. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end feeding the IF/ID pipeline register.
//
// The block owns the fetch PC and issues word-aligned requests to a
// synchronous instruction memory with one cycle of read latency. Returned
// words land in a small skid FIFO, so a decode stall never loses an
// instruction. A branch redirect from execute flushes the FIFO, drops any
// in-flight return and restarts fetch at the target.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   BranchTaken   redirect request from execute
//   BranchTarget  redirect address; bits [1:0] are ignored
//   StallD        decode cannot accept this cycle
//   IMemReq       fetch request strobe
//   IMemAddr      word-aligned fetch address
//   IMemData      instruction word, valid the cycle after IMemReq
//   InstrF        instruction at the FIFO head (0 when not valid)
//   PCF           address of InstrF (0 when not valid)
//   PCPlus4F      PCF + 4 (0 when not valid)
//   ValidF        InstrF/PCF/PCPlus4F hold a real instruction
module fetch_stage #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned      BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             StallD,
    output logic             IMemReq,
    output logic [WIDTH-1:0] IMemAddr,
    input  logic [WIDTH-1:0] IMemData,
    output logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic             ValidF
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // Wide enough to hold count + inflight, which can reach BUF_DEPTH + 1 transiently.
    localparam int unsigned OccW = PtrW + 2;

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [WIDTH-1:0] buf_instr_q [BUF_DEPTH];
    logic [WIDTH-1:0] buf_instr_d [BUF_DEPTH];
    logic [WIDTH-1:0] buf_pc_q [BUF_DEPTH];
    logic [WIDTH-1:0] buf_pc_d [BUF_DEPTH];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [OccW-1:0]  count_q, count_d;

    logic            valid;
    logic            pop;
    logic            push;
    logic            issue;
    logic [OccW-1:0] occupancy;

    always_comb begin
        valid     = (count_q != '0);
        pop       = valid & ~StallD & ~BranchTaken;
        // A return arriving during a redirect belongs to the squashed path.
        push      = inflight_q & ~BranchTaken;
        // Slots committed after this edge if nothing new is requested; issue only
        // while that leaves room for the word we are about to ask for.
        occupancy = count_q + OccW'(inflight_q) - OccW'(pop);
        // Gated by reset so no request escapes while reset is held low.
        issue     = reset & ~BranchTaken & (occupancy < OccW'(BUF_DEPTH));

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (BranchTaken) begin
            fetch_pc_d = {BranchTarget[WIDTH-1:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + WIDTH'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                buf_instr_d[tail_q] = IMemData;
                buf_pc_d[tail_q]    = inflight_pc_q;
                tail_d              = tail_q + PtrW'(1);
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            count_d = count_q + OccW'(push) - OccW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

    always_comb begin
        IMemReq  = issue;
        IMemAddr = fetch_pc_q;
        ValidF   = valid;
        InstrF   = valid ? buf_instr_q[head_q] : '0;
        PCF      = valid ? buf_pc_q[head_q] : '0;
        PCPlus4F = valid ? (buf_pc_q[head_q] + WIDTH'(4)) : '0;
    end

endmodule
